// File: rtl/sdram_burst_sched.sv
// sdram_burst_sched: SDRAM-side burst scheduler between a write/read FIFO pair and the SDRAM command core
// Ports:
//   i_sclk, i_s_rst        clock, asynchronous active-high reset
//   i_wr_trig, i_rd_trig   wfifo holds a burst / rfifo has room for a burst (levels)
//   o_wfifo_rd_en, i_wfifo_rd_data   wfifo read strobe and data (data 1 cycle after strobe)
//   o_rfifo_wr_en, o_rfifo_wr_data   rfifo write strobe and data
//   o_cmd_req, o_cmd_wr, o_cmd_addr, i_cmd_ack   burst request handshake to the core
//   i_wdata_req, o_wdata   core write-data request and data
//   i_rdata_vld, i_rdata   core read data
//   i_cmd_done             burst finished pulse
//   o_avail                written-but-unread bursts in the ring
module sdram_burst_sched #(
  parameter int BURST_LEN     = 256,
  parameter int ADDR_W        = 24,
  parameter int BASE_ADDR     = 0,
  parameter int REGION_BURSTS = 16
) (
  input  logic                               i_sclk,
  input  logic                               i_s_rst,
  input  logic                               i_wr_trig,
  input  logic                               i_rd_trig,
  output logic                               o_wfifo_rd_en,
  input  logic [15:0]                        i_wfifo_rd_data,
  output logic                               o_rfifo_wr_en,
  output logic [15:0]                        o_rfifo_wr_data,
  output logic                               o_cmd_req,
  output logic                               o_cmd_wr,
  output logic [ADDR_W-1:0]                  o_cmd_addr,
  input  logic                               i_cmd_ack,
  input  logic                               i_wdata_req,
  output logic [15:0]                        o_wdata,
  input  logic                               i_rdata_vld,
  input  logic [15:0]                        i_rdata,
  input  logic                               i_cmd_done,
  output logic [$clog2(REGION_BURSTS):0]     o_avail
);
  localparam int PW  = $clog2(REGION_BURSTS);
  localparam int AVW = PW + 1;
  localparam int CW  = $clog2(BURST_LEN) + 1;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RUN, RD_REQ, RD_RUN} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_wcnt;
  logic            r_prio_rd;
  logic            w_wr_ok, w_rd_ok, w_pick_wr;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [PW-1:0]   w_wr_nxt, w_rd_nxt;
  assign w_wr_ok   = i_wr_trig && (o_avail < AVW'(REGION_BURSTS));
  assign w_rd_ok   = i_rd_trig && (o_avail != '0);
  // r_prio_rd is set after a write is served, so reads win the next tie
  assign w_pick_wr = w_wr_ok && (!w_rd_ok || !r_prio_rd);
  assign w_wr_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_wr_ptr) * ADDR_W'(BURST_LEN);
  assign w_rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_rd_ptr) * ADDR_W'(BURST_LEN);
  assign w_wr_nxt  = (r_wr_ptr == PW'(REGION_BURSTS - 1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_nxt  = (r_rd_ptr == PW'(REGION_BURSTS - 1)) ? '0 : r_rd_ptr + 1'b1;
  // the strobe cap keeps surplus core requests from over-reading the wfifo
  assign o_wfifo_rd_en = (r_state == WR_RUN) && i_wdata_req && (r_wcnt < CW'(BURST_LEN));
  assign o_wdata       = i_wfifo_rd_data;
  always_ff @(posedge i_sclk or posedge i_s_rst) begin
    if (i_s_rst) begin
      r_state         <= IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_wcnt          <= '0;
      r_prio_rd       <= 1'b0;
      o_avail         <= '0;
      o_cmd_req       <= 1'b0;
      o_cmd_wr        <= 1'b0;
      o_cmd_addr      <= '0;
      o_rfifo_wr_en   <= 1'b0;
      o_rfifo_wr_data <= '0;
    end else begin
      o_rfifo_wr_en <= (r_state == RD_RUN) && i_rdata_vld;
      if ((r_state == RD_RUN) && i_rdata_vld) o_rfifo_wr_data <= i_rdata;
      case (r_state)
        IDLE: begin
          r_wcnt <= '0;
          if (w_wr_ok || w_rd_ok) begin
            r_state    <= w_pick_wr ? WR_REQ : RD_REQ;
            o_cmd_req  <= 1'b1;
            o_cmd_wr   <= w_pick_wr;
            o_cmd_addr <= w_pick_wr ? w_wr_addr : w_rd_addr;
          end
        end
        WR_REQ, RD_REQ: begin
          if (i_cmd_ack) begin
            o_cmd_req <= 1'b0;
            r_state   <= (r_state == WR_REQ) ? WR_RUN : RD_RUN;
          end
        end
        WR_RUN: begin
          if (o_wfifo_rd_en) r_wcnt <= r_wcnt + 1'b1;
          if (i_cmd_done) begin
            r_state   <= IDLE;
            r_wr_ptr  <= w_wr_nxt;
            o_avail   <= o_avail + 1'b1;
            r_prio_rd <= 1'b1;
          end
        end
        RD_RUN: begin
          if (i_cmd_done) begin
            r_state   <= IDLE;
            r_rd_ptr  <= w_rd_nxt;
            o_avail   <= o_avail - 1'b1;
            r_prio_rd <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_burst_sched.sv
// tb_sdram_burst_sched: directed/randomized bench for sdram_burst_sched with a queue-based ring model
module tb_sdram_burst_sched;
  logic        clk = 1'b0, rst = 1'b1;
  logic        wr_trig = 0, rd_trig = 0, cmd_ack = 0, wdata_req = 0, rdata_vld = 0, cmd_done = 0;
  logic [15:0] wfifo_rd_data = '0, rdata = '0, fifo_word = 16'h1000;
  logic        wfifo_rd_en, rfifo_wr_en, cmd_req, cmd_wr;
  logic [15:0] rfifo_wr_data, wdata;
  logic [23:0] cmd_addr;
  logic [4:0]  avail;
  int          n_cmp = 0, n_bad = 0;
  logic [23:0] q[$];
  int          wr_cnt = 0;
  bit          prio_rd = 0;
  sdram_burst_sched dut (
    .i_sclk(clk), .i_s_rst(rst), .i_wr_trig(wr_trig), .i_rd_trig(rd_trig),
    .o_wfifo_rd_en(wfifo_rd_en), .i_wfifo_rd_data(wfifo_rd_data),
    .o_rfifo_wr_en(rfifo_wr_en), .o_rfifo_wr_data(rfifo_wr_data),
    .o_cmd_req(cmd_req), .o_cmd_wr(cmd_wr), .o_cmd_addr(cmd_addr), .i_cmd_ack(cmd_ack),
    .i_wdata_req(wdata_req), .o_wdata(wdata), .i_rdata_vld(rdata_vld), .i_rdata(rdata),
    .i_cmd_done(cmd_done), .o_avail(avail)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (wfifo_rd_en) begin
    wfifo_rd_data <= fifo_word;
    fifo_word     <= fifo_word + 16'd1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, {cmd_req, cmd_wr}, 2'b00);
    chk({tag, "_addr"}, 64'(cmd_addr), 0);
    chk({tag, "_strobes"}, {wfifo_rd_en, rfifo_wr_en}, 2'b00);
    chk({tag, "_rdata"}, 64'(rfifo_wr_data), 0);
    chk({tag, "_avail"}, 64'(avail), 0);
  endtask
  // drop[1] releases wr_trig and drop[0] releases rd_trig once the request is accepted
  task automatic do_burst(input int nreq, input bit [1:0] drop);
    bit wok, rok, ew, v, pv;
    logic [23:0] ea;
    logic [15:0] d, pd, base;
    int t, got, sent, errs;
    wok = wr_trig && q.size() < 16;
    rok = rd_trig && q.size() > 0;
    ew  = wok && (!rok || !prio_rd);
    ea  = ew ? 24'((wr_cnt % 16) * 256) : q[0];
    t = 0;
    while (!cmd_req && t < 20) begin
      tick();
      t++;
    end
    chk("req_seen", 64'(cmd_req), 1);
    if (!cmd_req) return;
    chk("cmd_wr", 64'(cmd_wr), 64'(ew));
    chk("cmd_addr", 64'(cmd_addr), 64'(ea));
    repeat ($urandom_range(0, 3)) tick();
    chk("req_hold", {cmd_req, cmd_wr, cmd_addr}, {1'b1, ew, ea});
    cmd_ack = 1;
    tick();
    cmd_ack = 0;
    chk("req_drop", 64'(cmd_req), 0);
    if (drop[1]) wr_trig = 0;
    if (drop[0]) rd_trig = 0;
    if (ew) begin
      got = 0; sent = 0; base = fifo_word;
      while (sent < nreq) begin
        wdata_req = ($urandom_range(0, 3) != 0);
        #1;
        if (wfifo_rd_en) got++;
        if (wdata_req) sent++;
        tick();
      end
      wdata_req = 0;
      chk("wr_strobes", 64'(got), 64'(nreq < 256 ? nreq : 256));
      chk("wdata", 64'(wdata), 64'(16'(base + 16'(got) - 16'd1)));
    end else begin
      sent = 0; errs = 0; pv = 0; pd = '0;
      while (sent < 256 || pv) begin
        v = (sent < 256) && ($urandom_range(0, 3) != 0);
        d = 16'($urandom);
        rdata_vld = v; rdata = d;
        #1;
        if (rfifo_wr_en !== pv || (pv && rfifo_wr_data !== pd)) errs++;
        tick();
        if (v) sent++;
        pv = v; pd = d;
      end
      rdata_vld = 0;
      #1;
      chk("rd_stream", 64'(errs), 0);
      chk("rd_tail", 64'(rfifo_wr_en), 0);
    end
    cmd_done = 1;
    tick();
    cmd_done = 0;
    if (ew) begin
      q.push_back(ea);
      wr_cnt++;
    end else void'(q.pop_front());
    prio_rd = ew;
    chk("avail", 64'(avail), 64'(q.size()));
  endtask
  initial begin
    int hits, t;
    tick();
    #1;
    chk_zero("reset");
    rst = 0;
    tick();
    // reads are blocked while nothing has been written
    rd_trig = 1;
    hits = 0;
    repeat (100) begin
      tick();
      if (cmd_req) hits++;
    end
    chk("rd_blocked", 64'(hits), 0);
    wr_trig = 1;
    do_burst(300, 2'b10);
    do_burst(256, 2'b01);
    wr_trig = 1;
    do_burst(256, 2'b10);
    // stray core activity while idle must not move anything
    hits = 0;
    repeat (3) begin
      rdata_vld = 1; cmd_done = 1; wdata_req = 1; rdata = 16'hdead;
      #1;
      if (wfifo_rd_en) hits++;
      tick();
      if (rfifo_wr_en || cmd_req) hits++;
    end
    rdata_vld = 0; cmd_done = 0; wdata_req = 0;
    tick();
    chk("stray_idle", 64'(hits), 0);
    chk("stray_avail", 64'(avail), 64'(q.size()));
    // both directions eligible: round-robin
    wr_trig = 1; rd_trig = 1;
    for (int i = 0; i < 6; i++) do_burst(256, (i == 5) ? 2'b11 : 2'b00);
    // reset in the middle of a write burst
    wr_trig = 1;
    t = 0;
    while (!cmd_req && t < 20) begin
      tick();
      t++;
    end
    chk("rst_req_seen", 64'(cmd_req), 1);
    cmd_ack = 1;
    tick();
    cmd_ack = 0;
    wr_trig = 0;
    wdata_req = 1;
    repeat (100) tick();
    wdata_req = 0;
    rst = 1;
    #1;
    chk_zero("midrst");
    tick();
    rst = 0;
    tick();
    chk_zero("postrst");
    q.delete();
    wr_cnt = 0;
    prio_rd = 0;
    // fill the ring, then a write must wait for a read to free a slot
    wr_trig = 1;
    for (int i = 0; i < 16; i++) do_burst(256, 2'b00);
    chk("full_avail", 64'(avail), 16);
    hits = 0;
    repeat (50) begin
      tick();
      if (cmd_req) hits++;
    end
    chk("full_blocked", 64'(hits), 0);
    rd_trig = 1;
    do_burst(256, 2'b01);
    do_burst(256, 2'b10);
    chk("wrap_q_head", 64'(q[q.size() - 1]), 0);
    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
